// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice:
//   state_t          - arbiter FSM states (IDLE / BUSY / DONE)
//   PORT_CPU/PORT_LD - requester ids used for grant and last_grant
//   DEFAULT_LATENCY  - default data_memory access time in cycles
//   CNT_W            - width of the access-latency down counter (1..15)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses that meet at the arbiter:
//   cpu_*  - MEM-stage load/store request, stall back-pressure and load data
//   ld_*   - loader/debug port request, completion pulse and read data
//   dm_*   - strobes/address/data towards data_memory and its read result
// Modports:
//   slave  - arbiter view (requests in, responses and memory strobes out)
//   master - environment view (CPU, loader and data_memory side)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic [31:0] ld_rdata;

  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_result;

  modport slave (
    input  cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output dm_read, dm_write, dm_addr, dm_wdata,
    input  dm_result
  );

  modport master (
    output cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  dm_read, dm_write, dm_addr, dm_wdata,
    output dm_result
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant (CPU vs loader).
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   req_cpu       - CPU requester active
//   req_ld        - loader requester active
//   grant_en      - grant is being taken this cycle (arbiter in IDLE)
//   grant_valid   - at least one requester active
//   grant_id      - requester that wins (PORT_CPU / PORT_LD)
// On a tie the requester that did not win last time is chosen. last_grant
// resets to the loader so the CPU wins the first tie after reset.
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_ld,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant_reg;

  always_comb begin
    grant_valid = req_cpu | req_ld;
    if (req_cpu && req_ld) begin
      grant_id = ~last_grant_reg;
    end else if (req_ld) begin
      grant_id = PORT_LD;
    end else begin
      grant_id = PORT_CPU;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= PORT_LD;
    end else if (grant_en && grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data_memory between the CPU MEM stage and a loader/debug port.
// One access is outstanding at a time: IDLE samples requests and grants one,
// BUSY drives the memory strobes for exactly LATENCY cycles, DONE releases the
// requester for one cycle (CPU: stall drops, loader: ld_ack pulses).
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   bus          - dmem_arbiter_if.slave: cpu_*, ld_* and dm_* buses
// Parameter:
//   LATENCY      - data_memory access time in cycles, 1..15
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_arbiter: LATENCY must be within 1..15");
    end
  endgenerate

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               grant_reg;
  logic               dm_read_reg;
  logic               dm_write_reg;
  logic [31:0]        dm_addr_reg;
  logic [31:0]        dm_wdata_reg;
  logic               ld_ack_reg;
  logic [31:0]        cpu_rdata_reg;
  logic [31:0]        ld_rdata_reg;

  logic               cpu_act;
  logic               grant_valid;
  logic               grant_id;

  assign cpu_act = bus.cpu_memread | bus.cpu_memwrite;

  rr_arb2 u_rr_arb2 (
    .clock       (clock),
    .reset       (reset),
    .req_cpu     (cpu_act),
    .req_ld      (bus.ld_req),
    .grant_en    (state_reg == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      grant_reg     <= PORT_CPU;
      dm_read_reg   <= 1'b0;
      dm_write_reg  <= 1'b0;
      dm_addr_reg   <= '0;
      dm_wdata_reg  <= '0;
      ld_ack_reg    <= 1'b0;
      cpu_rdata_reg <= '0;
      ld_rdata_reg  <= '0;
    end else begin
      ld_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_reg <= grant_id;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= BUSY;
            if (grant_id == PORT_CPU) begin
              // A store wins over a load when both CPU strobes are set.
              dm_write_reg <= bus.cpu_memwrite;
              dm_read_reg  <= ~bus.cpu_memwrite;
              dm_addr_reg  <= bus.cpu_addr;
              dm_wdata_reg <= bus.cpu_wdata;
            end else begin
              dm_write_reg <= bus.ld_we;
              dm_read_reg  <= ~bus.ld_we;
              dm_addr_reg  <= bus.ld_addr;
              dm_wdata_reg <= bus.ld_wdata;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            // dm_read_reg still holds the latched op on this last BUSY cycle.
            if (dm_read_reg) begin
              if (grant_reg == PORT_CPU) begin
                cpu_rdata_reg <= bus.dm_result;
              end else begin
                ld_rdata_reg <= bus.dm_result;
              end
            end
            dm_read_reg  <= 1'b0;
            dm_write_reg <= 1'b0;
            ld_ack_reg   <= (grant_reg == PORT_LD);
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall every cycle the CPU has a request, except the DONE cycle of its own
  // access: the pipeline advances at the end of that cycle.
  assign bus.cpu_stall = cpu_act & ~((state_reg == DONE) && (grant_reg == PORT_CPU));
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.ld_ack    = ld_ack_reg;
  assign bus.ld_rdata  = ld_rdata_reg;
  assign bus.dm_read   = dm_read_reg;
  assign bus.dm_write  = dm_write_reg;
  assign bus.dm_addr   = dm_addr_reg;
  assign bus.dm_wdata  = dm_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with LATENCY=2. A behavioural data_memory
// answers dm_* combinationally and writes on the clock edge. Expected
// completions (data and grant order) are queued when a request is driven and
// consumed by a monitor at each CPU release / loader ack.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  logic clock;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural data_memory, word addressed.
  logic [31:0] mem [0:255];
  assign bus.dm_result = mem[bus.dm_addr[9:2]];
  always @(posedge clock) begin
    if (bus.dm_write) mem[bus.dm_addr[9:2]] = bus.dm_wdata;
  end

  int total = 0;
  int bad   = 0;

  exp_t cpu_q[$];
  exp_t ld_q[$];
  logic grant_q[$];

  int n_rd = 0, n_wr = 0, n_stall = 0, n_ack = 0, n_cpu_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: counts strobe/stall cycles and scores each completion.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.dm_read)   n_rd++;
      if (bus.dm_write)  n_wr++;
      if (bus.cpu_stall) n_stall++;
      if (bus.ld_ack) begin
        exp_t e;
        logic g;
        n_ack++;
        if (ld_q.size() == 0 || grant_q.size() == 0) begin
          check("ld_spurious_ack", 32'(ld_q.size()), 32'd1);
        end else begin
          e = ld_q.pop_front();
          g = grant_q.pop_front();
          check("ld_grant_order", {31'b0, 1'b1}, {31'b0, g});
          if (e.is_read) check("ld_rdata", bus.ld_rdata, e.data);
          $display("txn LD  done rdata=0x%08h", bus.ld_rdata);
        end
      end
      if ((bus.cpu_memread | bus.cpu_memwrite) && !bus.cpu_stall) begin
        exp_t e;
        logic g;
        n_cpu_done++;
        if (cpu_q.size() == 0 || grant_q.size() == 0) begin
          check("cpu_spurious_done", 32'(cpu_q.size()), 32'd1);
        end else begin
          e = cpu_q.pop_front();
          g = grant_q.pop_front();
          check("cpu_grant_order", {31'b0, 1'b0}, {31'b0, g});
          if (e.is_read) check("cpu_rdata", bus.cpu_rdata, e.data);
          $display("txn CPU done rdata=0x%08h", bus.cpu_rdata);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is released.
  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data);
    int base;
    logic got;
    cpu_q.push_back('{is_read: ~wr, data: exp_data});
    grant_q.push_back(1'b0);
    base = n_cpu_done;
    got  = 1'b0;
    bus.cpu_memread  = rd;
    bus.cpu_memwrite = wr;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (n_cpu_done > base) begin
        got = 1'b1;
        break;
      end
    end
    check("cpu_access_timeout", {31'b0, got}, 32'd1);
    #1;
    bus.cpu_memread  = 1'b0;
    bus.cpu_memwrite = 1'b0;
  endtask

  task automatic ld_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
    int base;
    logic got;
    ld_q.push_back('{is_read: ~we, data: exp_data});
    grant_q.push_back(1'b1);
    base = n_ack;
    got  = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_we    = we;
    bus.ld_addr  = addr;
    bus.ld_wdata = wdata;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (n_ack > base) begin
        got = 1'b1;
        break;
      end
    end
    check("ld_access_timeout", {31'b0, got}, 32'd1);
    #1;
    bus.ld_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, st0, ack0, done0;
    logic got;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEAD_BEEF;   // address 0x40
    reset            = 1'b1;
    bus.cpu_memread  = 1'b0;
    bus.cpu_memwrite = 1'b0;
    bus.cpu_addr     = 32'h0;
    bus.cpu_wdata    = 32'h0;
    bus.ld_req       = 1'b0;
    bus.ld_we        = 1'b0;
    bus.ld_addr      = 32'h0;
    bus.ld_wdata     = 32'h0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_dm_read",   {31'b0, bus.dm_read},   32'd0);
    check("rst_dm_write",  {31'b0, bus.dm_write},  32'd0);
    check("rst_ld_ack",    {31'b0, bus.ld_ack},    32'd0);
    check("rst_cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_ld_rdata",  bus.ld_rdata,  32'h0);
    check("rst_dm_addr",   bus.dm_addr,   32'h0);
    check("rst_dm_wdata",  bus.dm_wdata,  32'h0);
    @(posedge clock); #1;
    bus.cpu_memread = 1'b1;
    @(negedge clock);
    check("rst_cpu_stall_req", {31'b0, bus.cpu_stall}, 32'd1);
    @(posedge clock); #1;
    bus.cpu_memread = 1'b0;
    reset = 1'b0;

    // Reset during the 2nd BUSY cycle of a loader read aborts it.
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h40;
    @(posedge clock); #1;             // BUSY 1
    @(negedge clock);
    check("abort_busy_dm_read", {31'b0, bus.dm_read}, 32'd1);
    @(posedge clock); #1;             // BUSY 2
    reset      = 1'b1;
    bus.ld_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_dm_read",  {31'b0, bus.dm_read},  32'd0);
    check("abort_dm_write", {31'b0, bus.dm_write}, 32'd0);
    check("abort_ld_ack",   {31'b0, bus.ld_ack},   32'd0);
    check("abort_ld_rdata", bus.ld_rdata, 32'h0);
    ack0 = n_ack;
    repeat (4) @(posedge clock);
    #1;
    check("abort_no_ack", 32'(n_ack - ack0), 32'd0);
    $display("txn LD  read 0x40 aborted by reset");

    // CPU load 0x40: 3 stalled cycles, 2 read-strobe cycles.
    rd0 = n_rd; wr0 = n_wr; st0 = n_stall;
    cpu_access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    check("load_stall_cycles", 32'(n_stall - st0), 32'(LAT + 1));
    check("load_rd_cycles",    32'(n_rd - rd0),    32'(LAT));
    check("load_wr_cycles",    32'(n_wr - wr0),    32'd0);
    check("load_dm_addr_hold", bus.dm_addr, 32'h40);
    check("load_rdata_hold",   bus.cpu_rdata, 32'hDEAD_BEEF);

    // Loader write, then CPU reads it back.
    ack0 = n_ack; wr0 = n_wr;
    ld_access(1'b1, 32'h10, 32'h1234_5678, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("ldw_ack_pulses", 32'(n_ack - ack0), 32'd1);
    check("ldw_wr_cycles",  32'(n_wr - wr0),   32'(LAT));
    check("ldw_mem",        mem[4], 32'h1234_5678);
    cpu_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

    // Read+write together is a store.
    rd0 = n_rd; wr0 = n_wr;
    cpu_access(1'b1, 1'b1, 32'h8, 32'hA5, 32'h0);
    check("rw_rd_cycles", 32'(n_rd - rd0), 32'd0);
    check("rw_wr_cycles", 32'(n_wr - wr0), 32'(LAT));
    check("rw_mem",       mem[2], 32'h0000_00A5);
    check("rw_rdata_hold", bus.cpu_rdata, 32'h1234_5678);

    // Loader pulse while the CPU access is BUSY is never sampled.
    ack0  = n_ack;
    done0 = n_cpu_done;
    cpu_q.push_back('{is_read: 1'b1, data: 32'hDEAD_BEEF});
    grant_q.push_back(1'b0);
    bus.cpu_memread = 1'b1;
    bus.cpu_addr    = 32'h40;
    @(posedge clock); #1;             // BUSY 1
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h10;
    @(posedge clock); #1;             // BUSY 2
    bus.ld_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (n_cpu_done > done0) begin
        got = 1'b1;
        break;
      end
    end
    check("pulse_cpu_timeout", {31'b0, got}, 32'd1);
    #1;
    bus.cpu_memread = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("pulse_no_ack",    32'(n_ack - ack0), 32'd0);
    check("pulse_ld_rdata",  bus.ld_rdata, 32'h0);

    // Persistent tie after reset: CPU, LD, CPU, LD.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_q.push_back('{is_read: 1'b1, data: 32'hDEAD_BEEF});
      ld_q.push_back('{is_read: 1'b1, data: 32'h1234_5678});
      grant_q.push_back(1'b0);
      grant_q.push_back(1'b1);
    end
    done0 = n_cpu_done + n_ack;
    bus.cpu_memread = 1'b1;
    bus.cpu_addr    = 32'h40;
    bus.ld_req      = 1'b1;
    bus.ld_we       = 1'b0;
    bus.ld_addr     = 32'h10;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      if (n_cpu_done + n_ack >= done0 + 4) begin
        got = 1'b1;
        break;
      end
    end
    check("rr_timeout", {31'b0, got}, 32'd1);
    #1;
    bus.cpu_memread = 1'b0;
    bus.ld_req      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rr_ld_rdata", bus.ld_rdata, 32'h1234_5678);

    check("cpu_q_drained",   32'(cpu_q.size()),   32'd0);
    check("ld_q_drained",    32'(ld_q.size()),    32'd0);
    check("grant_q_drained", 32'(grant_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
